program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 18 +
 rtl/program_loader_if.sv | 34 +++
 rtl/loader_word_packer.sv | 35 +++
 rtl/program_loader.sv | 136 +++++++++++++
 tb/tb_program_loader.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and widths for the boot-time program loader.
// Imported by the loader FSM and its word packer.
package program_loader_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int BYTE_WIDTH  = 8;
    localparam int LEN_WIDTH   = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte stream and instruction-memory write bus of the loader.
// master is the loader side, slave is the stream source / memory side.
interface program_loader_if
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
);

    logic [BYTE_WIDTH-1:0]  rx_data;
    logic                   rx_valid;
    logic                   rx_ready;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [INSTR_WIDTH-1:0] mem_wdata;

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/loader_word_packer.sv
// Assembles four little-endian bytes into one instruction word.
// The byte index wraps to 0 after the fourth byte.
module loader_word_packer
    import program_loader_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   accept,
    input  logic [BYTE_WIDTH-1:0]  data,
    output logic [INSTR_WIDTH-1:0] word,
    output logic                   last_byte
);

    logic [1:0] byte_idx;

    assign last_byte = (byte_idx == 2'd3);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            byte_idx <= 2'd0;
            word     <= '0;
        end else if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            unique case (byte_idx)
                2'd0: word[7:0]   <= data;
                2'd1: word[15:8]  <= data;
                2'd2: word[23:16] <= data;
                2'd3: word[31:24] <= data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed program into instruction memory
// while holding the CPU in reset.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
)(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    program_loader_if.master         bus,
    output logic                     cpu_hold,
    output logic                     done,
    output logic                     len_error
);

    localparam int XW = LEN_WIDTH + 1;
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [XW-1:0] CAPACITY = XW'(1) << ADDR_WIDTH;

    state_t state_q, state_d;

    // One spare bit so a full-capacity load never wraps the index
    logic [CW-1:0]        word_idx;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] len_full;
    logic                 last_word;

    logic clear, accept, idx_inc;
    logic len_lo_we, len_hi_we, len_err_set;
    logic rx_ready, mem_we, last_byte;
    logic [INSTR_WIDTH-1:0] word;

    assign len_full  = {bus.rx_data, len_q[BYTE_WIDTH-1:0]};
    assign last_word = (XW'(word_idx) + XW'(1)) == {1'b0, len_q};

    assign bus.rx_ready  = rx_ready;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = word_idx[ADDR_WIDTH-1:0];
    assign bus.mem_wdata = word;

    loader_word_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .accept    (accept),
        .data      (bus.rx_data),
        .word      (word),
        .last_byte (last_byte)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            word_idx  <= '0;
            len_q     <= '0;
            len_error <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                word_idx  <= '0;
                len_error <= 1'b0;
            end else if (idx_inc) begin
                word_idx <= word_idx + CW'(1);
            end
            if (len_lo_we) len_q[7:0]  <= bus.rx_data;
            if (len_hi_we) len_q[15:8] <= bus.rx_data;
            if (len_err_set) len_error <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rx_ready    = 1'b0;
        mem_we      = 1'b0;
        cpu_hold    = 1'b1;
        done        = 1'b0;
        clear       = 1'b0;
        accept      = 1'b0;
        idx_inc     = 1'b0;
        len_lo_we   = 1'b0;
        len_hi_we   = 1'b0;
        len_err_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) begin
                    len_lo_we = 1'b1;
                    state_d   = LEN_HI;
                end
            end
            LEN_HI: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) begin
                    len_hi_we = 1'b1;
                    if (len_full == '0) begin
                        state_d = DONE;
                    end else if ({1'b0, len_full} > CAPACITY) begin
                        len_err_set = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                if (bus.rx_valid) begin
                    accept = 1'b1;
                    if (last_byte) state_d = WRITE;
                end
            end
            WRITE: begin
                mem_we  = 1'b1;
                idx_inc = 1'b1;
                state_d = last_word ? DONE : DATA;
            end
            DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (start) begin
                    clear   = 1'b1;
                    state_d = LEN_LO;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_program_loader;
    import program_loader_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic cpu_hold, done, len_error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  wr_addr [0:1023];
    logic [31:0] wr_data [0:1023];
    int          wr_cnt = 0;

    program_loader_if #(.ADDR_WIDTH(8)) bus ();

    program_loader #(.ADDR_WIDTH(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .bus       (bus),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .len_error (len_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.mem_we === 1'b1) begin
            if (wr_cnt < 1024) begin
                wr_addr[wr_cnt] <= bus.mem_addr;
                wr_data[wr_cnt] <= bus.mem_wdata;
            end
            wr_cnt <= wr_cnt + 1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap,
                             input bit hold);
        int n;
        if (gap > 0) begin
            bus.rx_valid = 1'b0;
            repeat (gap) @(negedge clock);
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        n = 0;
        while (bus.rx_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        n_checks++;
        assert (n < 50) else begin
            n_fail++;
            $error("FAIL rx_timeout: observed %0d cycles expected < 50", n);
        end
        @(negedge clock);
        if (!hold) bus.rx_valid = 1'b0;
    endtask

    logic [7:0] stream [0:9];
    int base;
    int bad;
    logic [7:0] bi;

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_rx_ready", bus.rx_ready, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_done", done, 0);
        check("rst_len_error", len_error, 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_rx_ready", bus.rx_ready, 0);

        // Two-word load
        base = wr_cnt;
        pulse_start();
        check("lenlo_rx_ready", bus.rx_ready, 1);
        send_byte(8'h02, 0, 0);
        send_byte(8'h00, 0, 0);
        send_byte(8'h13, 0, 0);
        send_byte(8'h05, 0, 0);
        send_byte(8'h80, 0, 0);
        send_byte(8'hD2, 0, 0);
        check("w0_we", bus.mem_we, 1);
        check("w0_addr", bus.mem_addr, 0);
        check("w0_data", bus.mem_wdata, 32'hD2800513);
        check("w0_rx_ready", bus.rx_ready, 0);
        check("w0_hold", cpu_hold, 1);
        send_byte(8'h00, 0, 0);
        send_byte(8'h00, 0, 0);
        send_byte(8'h00, 0, 0);
        send_byte(8'h14, 0, 0);
        check("w1_we", bus.mem_we, 1);
        check("w1_addr", bus.mem_addr, 1);
        check("w1_data", bus.mem_wdata, 32'h14000000);
        check("w1_done_early", done, 0);
        @(negedge clock);
        check("load_done", done, 1);
        check("load_hold", cpu_hold, 0);
        check("load_we_off", bus.mem_we, 0);
        check("load_rx_ready", bus.rx_ready, 0);
        check("load_wr_count", wr_cnt - base, 2);
        check("load_wr0_data", wr_data[base], 32'hD2800513);
        check("load_wr1_addr", wr_addr[base + 1], 1);

        // Restart from DONE, then zero-length load
        pulse_start();
        check("reload_done_clr", done, 0);
        check("reload_addr", bus.mem_addr, 0);
        check("reload_rx_ready", bus.rx_ready, 1);
        check("reload_hold", cpu_hold, 1);
        base = wr_cnt;
        send_byte(8'h00, 0, 0);
        send_byte(8'h00, 0, 0);
        check("len0_done", done, 1);
        check("len0_err", len_error, 0);
        @(negedge clock);
        check("len0_writes", wr_cnt - base, 0);

        // Oversize length 257
        pulse_start();
        base = wr_cnt;
        send_byte(8'h01, 0, 0);
        send_byte(8'h01, 0, 0);
        check("len257_err", len_error, 1);
        check("len257_done", done, 1);
        repeat (2) @(negedge clock);
        check("len257_writes", wr_cnt - base, 0);
        pulse_start();
        check("err_cleared", len_error, 0);

        // Full capacity 256 words
        base = wr_cnt;
        send_byte(8'h00, 0, 0);
        send_byte(8'h01, 0, 0);
        for (int i = 0; i < 256; i++) begin
            bi = 8'(i);
            send_byte(bi, 0, 0);
            send_byte(bi ^ 8'h5A, 0, 0);
            send_byte(~bi, 0, 0);
            send_byte(8'hC3, 0, 0);
        end
        check("cap_done_early", done, 0);
        @(negedge clock);
        check("cap_done", done, 1);
        check("cap_err", len_error, 0);
        check("cap_writes", wr_cnt - base, 256);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            bi = 8'(i);
            if (wr_addr[base + i] !== bi) bad++;
            if (wr_data[base + i] !== {8'hC3, ~bi, bi ^ 8'h5A, bi}) bad++;
        end
        check("cap_contents", bad, 0);

        // Gapped stream with rx_valid held through WRITE
        stream[0] = 8'h02; stream[1] = 8'h00;
        stream[2] = 8'h13; stream[3] = 8'h05;
        stream[4] = 8'h80; stream[5] = 8'hD2;
        stream[6] = 8'h00; stream[7] = 8'h00;
        stream[8] = 8'h00; stream[9] = 8'h14;
        pulse_start();
        base = wr_cnt;
        for (int i = 0; i < 10; i++) begin
            send_byte(stream[i], (i % 3 == 1) ? 0 : int'($urandom_range(0, 2)),
                      i != 9);
        end
        repeat (2) @(negedge clock);
        check("gap_done", done, 1);
        check("gap_writes", wr_cnt - base, 2);
        check("gap_w0", wr_data[base], 32'hD2800513);
        check("gap_w1", wr_data[base + 1], 32'h14000000);
        check("gap_a1", wr_addr[base + 1], 1);

        // start inside DATA is ignored
        pulse_start();
        base = wr_cnt;
        send_byte(8'h01, 0, 0);
        send_byte(8'h00, 0, 0);
        send_byte(8'h11, 0, 0);
        pulse_start();
        send_byte(8'h22, 0, 0);
        send_byte(8'h33, 0, 0);
        send_byte(8'h44, 0, 0);
        check("ign_we", bus.mem_we, 1);
        check("ign_data", bus.mem_wdata, 32'h44332211);
        @(negedge clock);
        check("ign_done", done, 1);
        check("ign_writes", wr_cnt - base, 1);

        // Reset mid-word beats start and rx_valid
        pulse_start();
        send_byte(8'h01, 0, 0);
        send_byte(8'h00, 0, 0);
        send_byte(8'hAA, 0, 0);
        send_byte(8'hBB, 0, 0);
        base = wr_cnt;
        reset = 1'b1;
        start = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hCC;
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        bus.rx_valid = 1'b0;
        check("mid_rst_rx_ready", bus.rx_ready, 0);
        check("mid_rst_hold", cpu_hold, 1);
        check("mid_rst_done", done, 0);
        check("mid_rst_wdata", bus.mem_wdata, 0);
        repeat (3) @(negedge clock);
        check("mid_rst_writes", wr_cnt - base, 0);
        pulse_start();
        send_byte(8'h01, 0, 0);
        send_byte(8'h00, 0, 0);
        send_byte(8'h78, 0, 0);
        send_byte(8'h56, 0, 0);
        send_byte(8'h34, 0, 0);
        send_byte(8'h12, 0, 0);
        check("fresh_we", bus.mem_we, 1);
        check("fresh_addr", bus.mem_addr, 0);
        check("fresh_data", bus.mem_wdata, 32'h12345678);
        @(negedge clock);
        check("fresh_done", done, 1);
        check("fresh_writes", wr_cnt - base, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
